icache_rf_ctrl: RTL

- Controller in front of the 2-read/2-write L1 icache SCM register file (tag/valid arrays).
- Auto-clears the whole array after reset and on `flush_req_i`, using both write ports in parallel.
- Outside a flush, maps two refill write requesters onto write ports A/B and arbitrates same-address conflicts.
- Gates the two lookup read ports while a flush is in progress.

---
 rtl/icache_rf_ctrl_if.sv | 31 +++
 rtl/icache_rf_ctrl.sv | 73 +++++++
 2 files changed

// File: rtl/icache_rf_ctrl_if.sv
// icache_rf_ctrl_if: flush, refill-write, lookup-read and register-file port bundle
interface icache_rf_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  flush_req_i, flush_busy_o, flush_done_o;
  logic                  wr0_req_i, wr0_gnt_o, wr1_req_i, wr1_gnt_o;
  logic [ADDR_WIDTH-1:0] wr0_addr_i, wr1_addr_i;
  logic [DATA_WIDTH-1:0] wr0_data_i, wr1_data_i;
  logic                  rd_a_req_i, rd_b_req_i, rd_a_gnt_o, rd_b_gnt_o;
  logic                  rd_a_valid_o, rd_b_valid_o;
  logic                  rf_ren_a_o, rf_ren_b_o, rf_we_a_o, rf_we_b_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_a_o, rf_waddr_b_o;
  logic [DATA_WIDTH-1:0] rf_wdata_a_o, rf_wdata_b_o;
  modport master (
    output flush_req_i, wr0_req_i, wr0_addr_i, wr0_data_i,
           wr1_req_i, wr1_addr_i, wr1_data_i, rd_a_req_i, rd_b_req_i,
    input  flush_busy_o, flush_done_o, wr0_gnt_o, wr1_gnt_o,
           rd_a_gnt_o, rd_b_gnt_o, rd_a_valid_o, rd_b_valid_o,
           rf_ren_a_o, rf_ren_b_o, rf_we_a_o, rf_we_b_o,
           rf_waddr_a_o, rf_waddr_b_o, rf_wdata_a_o, rf_wdata_b_o
  );
  modport slave (
    input  flush_req_i, wr0_req_i, wr0_addr_i, wr0_data_i,
           wr1_req_i, wr1_addr_i, wr1_data_i, rd_a_req_i, rd_b_req_i,
    output flush_busy_o, flush_done_o, wr0_gnt_o, wr1_gnt_o,
           rd_a_gnt_o, rd_b_gnt_o, rd_a_valid_o, rd_b_valid_o,
           rf_ren_a_o, rf_ren_b_o, rf_we_a_o, rf_we_b_o,
           rf_waddr_a_o, rf_waddr_b_o, rf_wdata_a_o, rf_wdata_b_o
  );
endinterface

// File: rtl/icache_rf_ctrl.sv
// icache_rf_ctrl: flush sequencer, refill write arbiter and read gating for the icache tag/valid RF
module icache_rf_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  icache_rf_ctrl_if.slave bus
);
  typedef enum logic {FLUSH, IDLE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2);
  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic                  pending, pending_n, prio, done_q, valid_a_q, valid_b_q;
  logic                  flushing, act, last, conf, gnt0, gnt1, rd_a, rd_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      cnt       <= '0;
      pending   <= 1'b0;
      prio      <= 1'b0;
      done_q    <= 1'b0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      prio      <= prio ^ conf;
      done_q    <= flushing & last;
      valid_a_q <= rd_a;
      valid_b_q <= rd_b;
    end
  end
  always_comb begin
    flushing  = !rst && state == FLUSH;
    act       = !rst && state == IDLE && !bus.flush_req_i;
    last      = cnt == LAST;
    conf      = act && bus.wr0_req_i && bus.wr1_req_i && bus.wr0_addr_i == bus.wr1_addr_i;
    gnt0      = act && bus.wr0_req_i && (!conf || !prio);
    gnt1      = act && bus.wr1_req_i && (!conf || prio);
    rd_a      = act && bus.rd_a_req_i;
    rd_b      = act && bus.rd_b_req_i;
    state_n   = state;
    cnt_n     = cnt;
    pending_n = pending;
    // a request seen in the final write cycle restarts directly instead of via pending
    if (state == FLUSH) begin
      cnt_n     = last ? '0 : cnt + ADDR_WIDTH'(2);
      pending_n = !last && (pending || bus.flush_req_i);
      state_n   = (!last || pending || bus.flush_req_i) ? FLUSH : IDLE;
    end else if (bus.flush_req_i) begin
      state_n = FLUSH;
      cnt_n   = '0;
    end
    bus.flush_busy_o = rst || state == FLUSH;
    bus.flush_done_o = !rst && done_q;
    bus.wr0_gnt_o    = gnt0;
    bus.wr1_gnt_o    = gnt1;
    bus.rd_a_gnt_o   = rd_a;
    bus.rd_b_gnt_o   = rd_b;
    bus.rf_ren_a_o   = rd_a;
    bus.rf_ren_b_o   = rd_b;
    bus.rd_a_valid_o = !rst && valid_a_q;
    bus.rd_b_valid_o = !rst && valid_b_q;
    bus.rf_we_a_o    = flushing || gnt0;
    bus.rf_we_b_o    = flushing || gnt1;
    bus.rf_waddr_a_o = flushing ? cnt : gnt0 ? bus.wr0_addr_i : '0;
    bus.rf_waddr_b_o = flushing ? (cnt | ADDR_WIDTH'(1)) : gnt1 ? bus.wr1_addr_i : '0;
    bus.rf_wdata_a_o = gnt0 ? bus.wr0_data_i : '0;
    bus.rf_wdata_b_o = gnt1 ? bus.wr1_data_i : '0;
  end
endmodule
